// File: rtl/minimig_resetctrl_pkg.sv
// Shared constants for the reset controller: cause-register bit positions and
// the per-domain release threshold used by both the top and each domain slice.
package minimig_resetctrl_pkg;

    localparam int CAUSE_POR      = 0;
    localparam int CAUSE_BOOTDONE = 1;
    localparam int CAUSE_SRC0     = 2;

    // Later domains wait 'stagger' extra pulses each so release is ordered by index.
    function automatic int thr(input int d, input int hold, input int stagger);
        return hold + d * stagger;
    endfunction

endpackage

// File: rtl/minimig_resetctrl_if.sv
// Control/status bundle between the reset controller and its environment.
// The master side drives the enables and requests; the slave side returns the resets.
interface minimig_resetctrl_if #(
    parameter int NSRC = 2,
    parameter int NDOM = 3
);
    logic            clk7_en;
    logic            cnt;
    logic [NSRC-1:0] req;
    logic            bootdone;
    logic            cause_clr;
    logic [NDOM-1:0] rst_out;
    logic            boot;
    logic [NSRC+1:0] cause;

    modport master (
        output clk7_en, cnt, req, bootdone, cause_clr,
        input  rst_out, boot, cause
    );

    modport slave (
        input  clk7_en, cnt, req, bootdone, cause_clr,
        output rst_out, boot, cause
    );
endinterface

// File: rtl/minimig_rstdom.sv
// One reset domain: pulse counter saturating at THR with a registered reset output.
// The output follows the counter's next value, so rst_out is 0 exactly when the counter sits at THR.
module minimig_rstdom #(
    parameter int CNT_W    = 4,
    parameter int THR      = 4,
    parameter bit FAST_SIM = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_cnt,
    input  logic i_clr,
    output logic o_rst
);
    localparam logic [CNT_W-1:0] THR_V = CNT_W'(THR);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_rst;

    always_comb begin
        w_count_nxt = r_count;
        if (i_clr) begin
            w_count_nxt = '0;
        end else if ((r_count != THR_V) && (i_cnt || FAST_SIM)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_rst   <= 1'b1;
        end else if (i_en) begin
            r_count <= w_count_nxt;
            r_rst   <= (w_count_nxt != THR_V);
        end
    end

    assign o_rst = r_rst;

endmodule

// File: rtl/minimig_resetctrl.sv
// Multi-source, multi-domain reset generator with staggered release, boot flag and sticky cause.
// Requests reach rst_out after 3 enabled cycles (2-flop sync + domain register); bootdone after 1.
module minimig_resetctrl
    import minimig_resetctrl_pkg::*;
#(
    parameter int                   NSRC     = 2,
    parameter int                   NDOM     = 3,
    parameter int                   CNT_W    = 4,
    parameter int                   HOLD     = 4,
    parameter int                   STAGGER  = 2,
    parameter logic [NSRC*NDOM-1:0] SRC_MASK = '1,
    parameter bit                   FAST_SIM = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    minimig_resetctrl_if.slave  bus
);
    localparam int               CAUSE_W   = NSRC + 2;
    localparam logic [CAUSE_W-1:0] CAUSE_RST = CAUSE_W'(1) << CAUSE_POR;

    logic [NSRC-1:0]    r_sync1;
    logic [NSRC-1:0]    r_sync2;
    logic               r_boot;
    logic [CAUSE_W-1:0] r_cause;
    logic [CAUSE_W-1:0] w_cause_set;
    logic [NDOM-1:0]    w_rst;

    // A source cause is latched on the edge its synchronised level rises.
    assign w_cause_set[CAUSE_POR]      = 1'b0;
    assign w_cause_set[CAUSE_BOOTDONE] = bus.bootdone;
    for (genvar gs = 0; gs < NSRC; gs++) begin : g_src
        assign w_cause_set[CAUSE_SRC0+gs] = r_sync1[gs] & ~r_sync2[gs];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_boot  <= 1'b1;
            r_cause <= CAUSE_RST;
        end else if (bus.clk7_en) begin
            r_sync1 <= bus.req;
            r_sync2 <= r_sync1;
            if (bus.bootdone) begin
                r_boot <= 1'b0;
            end
            r_cause <= (bus.cause_clr ? '0 : r_cause) | w_cause_set;
        end
    end

    for (genvar gd = 0; gd < NDOM; gd++) begin : g_dom
        logic [NSRC-1:0] w_hit;
        logic            w_clr;

        for (genvar gs = 0; gs < NSRC; gs++) begin : g_hit
            assign w_hit[gs] = r_sync2[gs] & SRC_MASK[gs*NDOM+gd];
        end
        assign w_clr = (|w_hit) | bus.bootdone;

        minimig_rstdom #(
            .CNT_W    (CNT_W),
            .THR      (thr(gd, HOLD, STAGGER)),
            .FAST_SIM (FAST_SIM)
        ) u_dom (
            .i_clk (i_clk),
            .i_rst (i_reset),
            .i_en  (bus.clk7_en),
            .i_cnt (bus.cnt),
            .i_clr (w_clr),
            .o_rst (w_rst[gd])
        );
    end

    assign bus.rst_out = w_rst;
    assign bus.boot    = r_boot;
    assign bus.cause   = r_cause;

endmodule

// File: doc/minimig_resetctrl.md
# minimig_resetctrl

Parametrised multi-source, multi-domain successor to the system reset generator. It accepts an asynchronous power-on reset and NSRC asynchronous reset requests, and produces NDOM stretched, staggered, synchronous reset outputs. It also keeps the bootrom `boot` flag and a sticky reset-cause register. It sits at top level beside gary; outputs feed the 68k bus, chipset and peripheral reset nets.

## Interface
- `NSRC`, 2: number of asynchronous reset request sources.
- `NDOM`, 3: number of reset output domains.
- `CNT_W`, 4: per-domain counter width.
- `HOLD`, 4: `cnt` pulses domain 0 stays in reset after all its requests drop.
- `STAGGER`, 2: extra pulses per domain index; domain i threshold is THR(i) = HOLD + i*STAGGER. Requires THR(NDOM-1) < 2^CNT_W and HOLD ≥ 1.
- `SRC_MASK`, all-ones: NSRC*NDOM bits; bit [s*NDOM+d] routes source s to domain d.
- `FAST_SIM`, 0: when 1, counters advance on every `clk7_en` regardless of `cnt`.
- `clk`  in  1  bus clock.
- `reset`  in  1  asynchronous, active-high power-on reset.
- `clk7_en`  in  1  clock enable; all state except async reset updates only when high.
- `cnt`  in  1  counting pulse, qualified by `clk7_en`.
- `req`  in  NSRC  asynchronous, level-sensitive reset requests.
- `bootdone`  in  1  synchronous pulse from gary; ends boot mode.
- `cause_clr`  in  1  synchronous pulse; clears `cause`.
- `rst_out`  out  NDOM  synchronous active-high domain resets.
- `boot`  out  1  bootrom-mapping flag.
- `cause`  out  NSRC+2  sticky causes: bit0 POR, bit1 bootdone, bit 2+s = source s.

## Operation
- Async `reset` values: all synchronizer stages 0, all counters 0, `rst_out` all ones, `boot` 1, `cause` = 1 (POR only).
- Each `req[s]` passes a 2-flop synchronizer clocked on `clk7_en`; the result is `sreq[s]`.
- Domain d clear term is OR over s of (`sreq[s]` AND mask bit [s*NDOM+d]), OR `bootdone`.
- Counter d, on `clk7_en`:
  - clear term high: counter ← 0.
  - otherwise, if counter ≠ THR(d) and (`cnt` or `FAST_SIM`): counter ← counter + 1.
  - otherwise: hold. The counter saturates at THR(d) and never wraps.
- `rst_out[d]` is registered: it is 1 while counter ≠ THR(d), and 0 when counter = THR(d).
- A held request keeps the counter at 0 for the whole time it is high. The hold period starts counting from its falling edge.
- `boot` is cleared by `bootdone` and set again only by async `reset`. Source requests never set `boot`.
- `cause` bits are set by async reset (bit0), `bootdone` (bit1) and `sreq[s]` rising to 1 (bit 2+s).
- `cause_clr` clears all `cause` bits. If a set and `cause_clr` occur in the same enabled cycle, the set wins for that bit.
- Reset mid-hold: a new request during a domain's hold restarts that domain from 0. Other domains are unaffected unless they are masked in.

## Timing
- `req` to `rst_out` assertion: 3 enabled cycles (2 synchronizer stages, then counter/output register).
- `bootdone` to `rst_out` assertion: 1 enabled cycle. `boot` falls in the same cycle `rst_out` rises.
- Release: domain d deasserts on the enabled cycle after its THR(d)-th qualifying `cnt` following the clear term going low.
- With no `clk7_en`, nothing changes except on async `reset`.
- Release is ordered: domain 0 first, then domain d follows d*STAGGER qualifying pulses later, when all domains were cleared together.

## Structure
- Shared package holds the cause bit indices (`CAUSE_POR` = 0, `CAUSE_BOOTDONE` = 1, `CAUSE_SRC0` = 2) and the THR(d) function.
- One sub-module, `minimig_rstdom`, holds one domain's counter, threshold compare and output register. It is instantiated NDOM times via generate.
- The synchronizers, `boot` and `cause` logic stay in the top module.

## Test plan
- POR with defaults, `cnt` every enabled cycle:
  - `rst_out` = 111 during reset.
  - After release, domain 0 falls after 4 pulses, domain 1 after 6, domain 2 after 8.
  - `boot` = 1, `cause` = 0001.
- `bootdone` pulse in RUN: all `rst_out` = 1 next enabled cycle, `boot` = 0, `cause` bit1 set, staggered release repeats.
- `req[1]` held 20 cycles with `SRC_MASK` routing it to domain 2 only:
  - only `rst_out[2]` asserts, 3 enabled cycles after `req`.
  - it releases 8 pulses after `req` drops.
  - `boot` stays 0, `cause` bit3 set.
- Re-request during hold: `req[0]` pulses again when domain 0 counter = 3 → counter returns to 0 and `rst_out[0]` stays high for 4 more pulses after the drop.
- `cnt` held 0, `FAST_SIM` = 0 → `rst_out` stays 111 indefinitely. Same stimulus with `FAST_SIM` = 1 → normal staggered release.
- `cause_clr` in the same cycle as the `req[0]` rising edge → bit2 remains set and all other bits clear. Async `reset` asserted mid-hold → immediate `rst_out` = 111, `boot` = 1, `cause` = 0001.
